aoc_day: RTL and testbench

Single-character streaming solver for the "floor counting" puzzle (Advent of Code 2015 day 1). One ASCII character arrives per clock. Part 1 produces the running floor; part 2 reports the 1-based position of the first character that takes the floor to −1. The block sits behind a character-feeding bench or front end that loops `result_out` back into `result_in` every cycle.

---
 rtl/aoc_day_pkg.sv | 16 +
 rtl/aoc_char_decode.sv | 30 +++
 rtl/aoc_day.sv | 73 +++++++
 tb/tb_aoc_day.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/aoc_day_pkg.sv
// Shared constants and types for the floor-counting stream solver.
//   CH_OPEN / CH_CLOSE : bytes that move the floor up / down
//   CH_NUL             : padding byte, never counted as a position
//   RES_W              : width of the result, floor and position registers
//   delta_t            : signed per-character floor step (-1, 0, +1)
package aoc_day_pkg;

    localparam int unsigned RES_W = 32;

    localparam logic [7:0] CH_OPEN  = 8'h28;
    localparam logic [7:0] CH_CLOSE = 8'h29;
    localparam logic [7:0] CH_NUL   = 8'h00;

    typedef logic signed [1:0] delta_t;

endpackage

// File: rtl/aoc_char_decode.sv
// Combinational character decoder.
//   input_char : ASCII byte for this cycle
//   delta      : +1 for '(', -1 for ')', 0 for anything else
//   valid      : byte counts as a position (not NUL, no unknown bits)
module aoc_char_decode
    import aoc_day_pkg::*;
(
    input  logic [7:0] input_char,
    output delta_t     delta,
    output logic       valid
);

    always_comb begin
        delta = '0;
        // Unknown bytes fall through to default and produce no step.
        case (input_char)
            CH_OPEN:  delta = 2'sd1;
            CH_CLOSE: delta = -2'sd1;
            default:  delta = '0;
        endcase
    end

    always_comb begin
        valid = 1'b0;
        if (!$isunknown(input_char) && (input_char != CH_NUL)) begin
            valid = 1'b1;
        end
    end

endmodule

// File: rtl/aoc_day.sv
// Streaming solver for the floor-counting puzzle, one character per clock.
//   PART       : 2 selects first-basement search, any other value running floor
//   clk        : clock, all state on rising edge
//   rst        : synchronous active-high reset
//   input_char : ASCII byte for this cycle
//   result_in  : previous result looped back by the feeder (running floor only)
//   result_out : registered result
module aoc_day
    import aoc_day_pkg::*;
#(
    parameter int PART = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [7:0]              input_char,
    input  logic signed [RES_W-1:0] result_in,
    output logic signed [RES_W-1:0] result_out
);

    delta_t                  delta;
    logic                    valid;
    logic signed [RES_W-1:0] delta_ext;

    aoc_char_decode u_decode (
        .input_char (input_char),
        .delta      (delta),
        .valid      (valid)
    );

    assign delta_ext = $signed({{(RES_W-2){delta[1]}}, delta});

    if (PART == 2) begin : g_part2
        logic signed [RES_W-1:0] floor_q;
        logic        [RES_W-1:0] pos_q;
        logic                    found_q;
        logic signed [RES_W-1:0] floor_next;
        logic                    unused_result_in;

        // The feedback path carries no information in this mode.
        assign unused_result_in = ^result_in;
        assign floor_next       = floor_q + delta_ext;

        always_ff @(posedge clk) begin
            if (rst) begin
                floor_q    <= '0;
                pos_q      <= '0;
                found_q    <= 1'b0;
                result_out <= '0;
            end else if (valid && !found_q) begin
                pos_q   <= pos_q + 1'b1;
                floor_q <= floor_next;
                if (floor_next == -32'sd1) begin
                    found_q    <= 1'b1;
                    result_out <= $signed(pos_q + 1'b1);
                end
            end
        end
    end else begin : g_part1
        logic unused_valid;

        // Accumulation lives outside; only the NUL/unknown filter is unused here.
        assign unused_valid = valid;

        always_ff @(posedge clk) begin
            if (rst) begin
                result_out <= '0;
            end else begin
                result_out <= result_in + delta_ext;
            end
        end
    end

endmodule

// File: tb/tb_aoc_day.sv
// Bench for aoc_day: three instances (PART 1, PART 2, and out-of-range PART 0
// which must behave as PART 1) share one character stream. A history of every
// byte since the last reset is replayed against the puzzle rules each cycle.
module tb_aoc_day;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [7:0]         input_char = 8'h00;
    logic signed [31:0] result_in1 = 0;
    logic signed [31:0] result_in2 = 0;
    logic signed [31:0] result_in0 = 0;
    logic signed [31:0] res1, res2, res0;

    int pass_cnt  = 0;
    int total_cnt = 0;
    bit started   = 1'b0;

    logic [7:0] hist[$];

    always #5 clk = ~clk;

    aoc_day #(.PART(1)) dut1 (
        .clk (clk), .rst (rst), .input_char (input_char),
        .result_in (result_in1), .result_out (res1)
    );
    aoc_day #(.PART(2)) dut2 (
        .clk (clk), .rst (rst), .input_char (input_char),
        .result_in (result_in2), .result_out (res2)
    );
    aoc_day #(.PART(0)) dut0 (
        .clk (clk), .rst (rst), .input_char (input_char),
        .result_in (result_in0), .result_out (res0)
    );

    function automatic int dlt(input logic [7:0] c);
        if (c == 8'h28) return 1;
        if (c == 8'h29) return -1;
        return 0;
    endfunction

    // Running floor: sum of all steps since reset.
    function automatic int exp_p1();
        int s = 0;
        foreach (hist[i]) s += dlt(hist[i]);
        return s;
    endfunction

    // First 1-based position (counting non-NUL bytes) whose prefix floor is -1.
    function automatic int exp_p2();
        int f = 0;
        int p = 0;
        foreach (hist[i]) begin
            if (hist[i] != 8'h00) begin
                p++;
                f += dlt(hist[i]);
                if (f == -1) return p;
            end
        end
        return 0;
    endfunction

    function automatic void chk(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            hist.delete();
            started <= 1'b1;
        end else begin
            hist.push_back(input_char);
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("cycle_part1", res1, exp_p1());
            chk("cycle_part2", res2, exp_p2());
            chk("cycle_part_other", res0, exp_p1());
        end
    end

    // Drive one byte, return just after the edge that consumes it.
    task automatic feed(input logic [7:0] c);
        @(negedge clk);
        #1;
        rst        = 1'b0;
        input_char = c;
        result_in1 = res1;
        result_in0 = res0;
        result_in2 = $signed($urandom);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst        = 1'b1;
        input_char = 8'h29;
        result_in1 = $signed($urandom);
        result_in0 = $signed($urandom);
        result_in2 = $signed($urandom);
        @(posedge clk);
        #1;
    endtask

    task automatic feed_str(input string s);
        for (int i = 0; i < s.len(); i++) feed(s[i]);
    endtask

    initial begin
        do_reset();
        chk("reset_p1", res1, 0);
        chk("reset_p2", res2, 0);

        // Part 1: (()) gives 1,2,1,0
        feed("("); chk("p1_seq0", res1, 1);
        feed("("); chk("p1_seq1", res1, 2);
        feed(")"); chk("p1_seq2", res1, 1);
        feed(")"); chk("p1_seq3", res1, 0);

        do_reset();
        feed_str(")))(");
        chk("p1_down", res1, -2);

        do_reset();
        feed_str("))(((((");
        chk("p1_up", res1, 3);
        chk("p1_up_other_part", res0, 3);

        do_reset();
        feed("(");  chk("p1_mix0", res1, 1);
        feed("x");  chk("p1_mix1", res1, 1);
        feed(8'h0a); chk("p1_mix2", res1, 1);
        feed(")");  chk("p1_mix3", res1, 0);

        // Part 2
        do_reset();
        feed(")");
        chk("p2_first", res2, 1);

        do_reset();
        feed_str("()())");
        chk("p2_five", res2, 5);
        for (int i = 0; i < 10; i++) feed(")");
        chk("p2_hold", res2, 5);

        do_reset();
        feed_str("(((");
        for (int i = 0; i < 5; i++) feed(8'h00);
        chk("p2_never", res2, 0);

        // NUL bytes do not advance the position: (, NUL, ), ) -> position 3
        do_reset();
        feed("("); feed(8'h00); feed(")"); feed(")");
        chk("p2_nul_skip", res2, 3);

        // Reset mid-stream
        do_reset();
        feed_str("(()");
        do_reset();
        chk("p2_mid_reset", res2, 0);
        feed(")");
        chk("p2_after_reset", res2, 1);

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
